snap_capture_ctrl: RTL and testbench
====================================

Name: snap_capture_ctrl

Overview:
- Snapshot capture controller that sits directly upstream of the dual-port BRAM wrapper's user port.
- Qualifies an incoming sample stream against an arm/trigger sequence and generates the user-side write stream (address, data, write enable) that fills the buffer exactly once per arm.
- Exposes done/busy/word-count status to software registers so the CPU knows when the buffer is safe to read over Wishbone.
- Control inputs arrive already synchronised to user_clk.

Parameters:
- USER_ADDR_BITS, 10, buffer address width; depth = 2^USER_ADDR_BITS words.
- DATA_WIDTH, 32, sample and BRAM word width; must equal the buffer's user-port width.
- OFFSET_BITS, 32, width of the post-trigger delay counter.

Ports:
- user_clk  in  1  capture clock; all logic on the rising edge.
- user_rst  in  1  synchronous, active-high reset.
- ctrl_arm  in  1  software arm level; a rising edge arms a capture.
- ctrl_trig_sel  in  1  1 = wait for trig; 0 = trigger immediately once armed.
- ctrl_vld_sel  in  1  1 = write only cycles with din_vld = 1; 0 = write every cycle.
- trig_offset  in  OFFSET_BITS  user_clk cycles between trigger and first write.
- din  in  DATA_WIDTH  sample data.
- din_vld  in  1  sample qualifier.
- trig  in  1  external trigger, level-sampled.
- bram_addr  out  USER_ADDR_BITS  to buffer user_addr.
- bram_din  out  DATA_WIDTH  to buffer user_din.
- bram_we  out  1  to buffer user_we.
- status_busy  out  1  high in ARMED, DELAY or CAPTURE.
- status_done  out  1  high in DONE.
- status_count  out  USER_ADDR_BITS+1  words written since the last arm.

Behaviour:
- Reset: state IDLE; all outputs 0, including bram_we, bram_addr, bram_din and status_count. The arm edge detector's previous-value register is cleared to 0.
- Reset mid-operation: same as reset. bram_we is 0 from the next edge. The partially written buffer is left as-is.
- Arm edge: arm_edge = ctrl_arm & ~arm_q, where arm_q is ctrl_arm registered.
  - Honoured only in IDLE or DONE; ignored in every other state.
  - ctrl_arm held high does not re-arm.
- States and transitions:
  - IDLE: on arm_edge go to ARMED; clear status_count and the internal write pointer to 0; status_done goes to 0.
  - ARMED: trigger event = (ctrl_trig_sel == 0) or (trig == 1).
    - On a trigger event with trig_offset == 0, go directly to CAPTURE. The trigger cycle counts as the first capture cycle.
    - On a trigger event with trig_offset == N > 0, load the delay counter with N and go to DELAY.
  - DELAY: decrement the counter once per cycle. On the cycle the counter is 1, go to CAPTURE. The first capture cycle therefore falls exactly N cycles after the trigger cycle.
  - CAPTURE: a cycle is qualified if ctrl_vld_sel == 0, or din_vld == 1.
    - Qualified cycle: register bram_we = 1, bram_addr = pointer, bram_din = din; then increment pointer and status_count.
    - Unqualified cycle: bram_we = 0; bram_addr and bram_din hold.
    - When the write to address 2^USER_ADDR_BITS − 1 is issued, go to DONE on the same edge. No wrap-around; the pointer never returns to 0 during a capture.
  - DONE: bram_we = 0 and status_done = 1. status_count holds 2^USER_ADDR_BITS. On arm_edge, behave exactly as IDLE.
- Latency: din sampled at edge k appears on bram_din/bram_we at edge k+1 (one register stage). The buffer adds its own write timing downstream.
- Configuration sampling: trig_offset is sampled only at the trigger event. ctrl_trig_sel is evaluated only in ARMED. ctrl_vld_sel is evaluated every CAPTURE cycle.
- Simultaneous events:
  - trig high in the same cycle the arm edge is detected is not a trigger; the arm edge is processed in IDLE/DONE.
  - trig pulses after the trigger event are ignored.
  - arm_edge during DONE re-arms and clears done in the same edge.
- status_busy and status_done are registered and mutually exclusive.

Test Plan:
- Reset mid-capture: reset asserted while in CAPTURE at pointer 100 → next cycle bram_we = 0, status_count = 0, state IDLE.
- Immediate free-run: ctrl_trig_sel = 0, ctrl_vld_sel = 0, trig_offset = 0, din = cycle counter, arm rise at cycle 10 →
  - first write at cycle 12, addr 0, data = din at cycle 11;
  - exactly 1024 writes on consecutive cycles, addresses 0..1023;
  - status_done = 1 after the last write, status_count = 1024.
- External trigger with offset: ctrl_trig_sel = 1, trig_offset = 5, trig pulse at cycle T → first bram_we at T+6 with data sampled at T+5; no writes before.
- Valid gating: ctrl_vld_sel = 1, din_vld toggling 1,0,1,0 → bram_we follows it one cycle later; 1024 writes with no address gaps; capture takes 2048 cycles.
- Re-arm rules:
  - second arm rise during CAPTURE → ignored; count continues.
  - arm held high after DONE → no re-arm.
  - arm low then high → status_done = 0, status_count = 0, new capture starts from addr 0.

Source files
------------

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arm/trigger/delay sequencing that fills the BRAM user port exactly once per arm.
// Latency: din at edge k appears on bram_din/bram_we at edge k+1; no backpressure, the buffer accepts every write.
module snap_capture_ctrl #(
    parameter int USER_ADDR_BITS = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int OFFSET_BITS    = 32
) (
    input  logic                      user_clk,
    input  logic                      user_rst,
    input  logic                      ctrl_arm,
    input  logic                      ctrl_trig_sel,
    input  logic                      ctrl_vld_sel,
    input  logic [OFFSET_BITS-1:0]    trig_offset,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      din_vld,
    input  logic                      trig,
    output logic [USER_ADDR_BITS-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    output logic                      bram_we,
    output logic                      status_busy,
    output logic                      status_done,
    output logic [USER_ADDR_BITS:0]   status_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [USER_ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t                    state;
    logic                      arm_q;
    logic [OFFSET_BITS-1:0]    delay_cnt;
    logic [USER_ADDR_BITS-1:0] wr_ptr;

    logic arm_edge;
    logic trig_event;
    logic cap_cycle;
    logic qualified;

    // The trigger cycle (zero offset) and the last delay cycle are themselves capture cycles.
    always_comb begin
        arm_edge   = ctrl_arm & ~arm_q;
        trig_event = (state == ARMED) && (!ctrl_trig_sel || trig);
        cap_cycle  = (state == CAPTURE)
                  || (trig_event && (trig_offset == '0))
                  || ((state == DELAY) && (delay_cnt == OFFSET_BITS'(1)));
        qualified  = !ctrl_vld_sel || din_vld;
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state        <= IDLE;
            arm_q        <= 1'b0;
            delay_cnt    <= '0;
            wr_ptr       <= '0;
            bram_addr    <= '0;
            bram_din     <= '0;
            bram_we      <= 1'b0;
            status_busy  <= 1'b0;
            status_done  <= 1'b0;
            status_count <= '0;
        end else begin
            arm_q   <= ctrl_arm;
            bram_we <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (arm_edge) begin
                        state        <= ARMED;
                        wr_ptr       <= '0;
                        status_count <= '0;
                        status_busy  <= 1'b1;
                        status_done  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trig_event && (trig_offset != '0)) begin
                        delay_cnt <= trig_offset;
                        state     <= DELAY;
                    end
                end
                DELAY: begin
                    if (delay_cnt != OFFSET_BITS'(1))
                        delay_cnt <= delay_cnt - 1'b1;
                end
                CAPTURE: ;
                default: state <= IDLE;
            endcase

            // Later assignments here override the transitions chosen above.
            if (cap_cycle) begin
                state <= CAPTURE;
                if (qualified) begin
                    bram_we      <= 1'b1;
                    bram_addr    <= wr_ptr;
                    bram_din     <= din;
                    status_count <= status_count + 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        state       <= DONE;
                        status_busy <= 1'b0;
                        status_done <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Bench for snap_capture_ctrl: random per-cycle stimulus windows scored against a
// write-list model derived from arm cycle, trigger cycle, offset and qualified cycles.
module tb_snap_capture_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int OW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int MAXL  = 3000;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic          ctrl_arm, ctrl_trig_sel, ctrl_vld_sel;
    logic [OW-1:0] trig_offset;
    logic [DW-1:0] din;
    logic          din_vld, trig;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we, status_busy, status_done;
    logic [AW:0]   status_count;

    always #5 user_clk = ~user_clk;

    snap_capture_ctrl #(.USER_ADDR_BITS(AW), .DATA_WIDTH(DW), .OFFSET_BITS(OW)) dut (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .ctrl_arm     (ctrl_arm),
        .ctrl_trig_sel(ctrl_trig_sel),
        .ctrl_vld_sel (ctrl_vld_sel),
        .trig_offset  (trig_offset),
        .din          (din),
        .din_vld      (din_vld),
        .trig         (trig),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_we      (bram_we),
        .status_busy  (status_busy),
        .status_done  (status_done),
        .status_count (status_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // stimulus window
    int            len;
    logic          sc_ts, sc_vs;
    logic          s_arm [MAXL];
    logic          s_trig[MAXL];
    logic          s_vld [MAXL];
    logic [DW-1:0] s_din [MAXL];
    logic [OW-1:0] s_off [MAXL];
    // observations
    logic          o_we[MAXL], o_busy[MAXL], o_done[MAXL];
    logic [AW-1:0] o_addr[MAXL];
    logic [DW-1:0] o_din[MAXL];
    logic [AW:0]   o_cnt[MAXL];
    // expectations
    logic          e_we[MAXL], e_busy[MAXL], e_done[MAXL];
    logic [AW-1:0] e_addr[MAXL];
    logic [DW-1:0] e_din[MAXL];
    logic [AW:0]   e_cnt[MAXL];
    logic [DW-1:0] e_wd[MAXL];

    // state carried from one window to the next
    logic          m_arm_prev = 1'b0;
    logic          m_busy = 1'b0, m_done = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic [AW:0]   m_cnt = '0;

    task automatic gen(input int kind);
        int a;
        for (int r = 0; r < MAXL; r++) begin
            s_arm[r]  = 1'b0;
            s_trig[r] = ($urandom_range(0, 7) == 0);
            s_vld[r]  = ($urandom_range(0, 3) != 0);
            s_din[r]  = $urandom;
            s_off[r]  = OW'($urandom_range(0, 7));
        end
        a = 3 + $urandom_range(0, 9);
        sc_ts = $urandom_range(0, 1) == 1;
        sc_vs = $urandom_range(0, 1) == 1;
        len = 2600;
        case (kind)
            0: begin // immediate free-run, din = cycle counter
                a = 10; sc_ts = 0; sc_vs = 0; len = 1100;
                for (int r = 0; r < MAXL; r++) begin s_din[r] = DW'(r); s_off[r] = '0; end
            end
            1: begin // external trigger at 40 with offset 5, trig on the arm-edge cycle too
                a = 4; sc_ts = 1; sc_vs = 0; len = 1120;
                for (int r = 0; r <= 40; r++) s_trig[r] = 1'b0;
                s_trig[4] = 1'b1; s_trig[40] = 1'b1; s_off[40] = OW'(5);
            end
            2: begin // din_vld toggling, second arm rise mid-capture
                a = 6; sc_ts = 0; sc_vs = 1; len = 2200;
                for (int r = 0; r < MAXL; r++) s_vld[r] = r[0];
            end
            3: begin // offset 1, arm still held from the previous window
                a = 8; sc_ts = 1; sc_vs = 0; len = 1200;
                for (int r = 0; r < MAXL; r++) s_off[r] = OW'(1);
            end
            default: begin
                s_trig[a] = 1'b1;
                s_trig[a + 20] = 1'b1;
            end
        endcase
        for (int r = a; r < MAXL; r++) s_arm[r] = 1'b1;
        if (kind == 2) for (int r = 600; r < 610; r++) s_arm[r] = 1'b0;
        if (kind == 3) begin
            for (int r = 0; r < 3; r++) s_arm[r] = 1'b1;
            s_trig[a + 20] = 1'b1;
        end
    endtask

    task automatic model();
        int a, t, s, n, done_at, k;
        logic          pa;
        logic [AW:0]   cnt;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        a = -1;
        for (int r = 0; r < len; r++) begin
            pa = (r == 0) ? m_arm_prev : s_arm[r-1];
            if (a < 0 && s_arm[r] && !pa) a = r;
        end
        t = -1;
        if (a >= 0)
            for (int r = a + 1; r < len; r++)
                if (t < 0 && (!sc_ts || s_trig[r])) t = r;
        for (int r = 0; r < len; r++) e_we[r] = 1'b0;
        n = 0;
        done_at = -1;
        if (t >= 0) begin
            s = t + int'(s_off[t]);
            for (int c = s; c < len - 1 && n < DEPTH; c++) begin
                if (!sc_vs || s_vld[c]) begin
                    e_we[c+1] = 1'b1;
                    e_wd[c+1] = s_din[c];
                    n++;
                    if (n == DEPTH) done_at = c + 1;
                end
            end
        end
        cnt = m_cnt; ad = m_addr; dd = m_din; k = 0;
        for (int r = 0; r < len; r++) begin
            if (a >= 0 && r == a + 1) begin cnt = '0; k = 0; end
            if (e_we[r]) begin
                ad = AW'(k); dd = e_wd[r]; k++; cnt = cnt + 1'b1;
            end
            e_addr[r] = ad; e_din[r] = dd; e_cnt[r] = cnt;
            if (a < 0 || r <= a) begin
                e_busy[r] = m_busy; e_done[r] = m_done;
            end else if (done_at >= 0 && r >= done_at) begin
                e_busy[r] = 1'b0; e_done[r] = 1'b1;
            end else begin
                e_busy[r] = 1'b1; e_done[r] = 1'b0;
            end
        end
        m_arm_prev = s_arm[len-1];
        m_busy = e_busy[len-1]; m_done = e_done[len-1];
        m_addr = e_addr[len-1]; m_din = e_din[len-1]; m_cnt = e_cnt[len-1];
    endtask

    task automatic run_and_check(input int sc);
        for (int r = 0; r < len; r++) begin
            @(posedge user_clk); #1;
            ctrl_arm      = s_arm[r];
            ctrl_trig_sel = sc_ts;
            ctrl_vld_sel  = sc_vs;
            trig          = s_trig[r];
            din_vld       = s_vld[r];
            din           = s_din[r];
            trig_offset   = s_off[r];
            @(negedge user_clk);
            o_we[r] = bram_we; o_addr[r] = bram_addr; o_din[r] = bram_din;
            o_busy[r] = status_busy; o_done[r] = status_done; o_cnt[r] = status_count;
        end
        for (int r = 0; r < len; r++) begin
            chk($sformatf("s%0d.we@%0d", sc, r),    o_we[r],   e_we[r]);
            chk($sformatf("s%0d.addr@%0d", sc, r),  o_addr[r], e_addr[r]);
            chk($sformatf("s%0d.din@%0d", sc, r),   o_din[r],  e_din[r]);
            chk($sformatf("s%0d.busy@%0d", sc, r),  o_busy[r], e_busy[r]);
            chk($sformatf("s%0d.done@%0d", sc, r),  o_done[r], e_done[r]);
            chk($sformatf("s%0d.count@%0d", sc, r), o_cnt[r],  e_cnt[r]);
        end
    endtask

    initial begin
        logic found;
        user_rst = 1'b1; ctrl_arm = 0; ctrl_trig_sel = 0; ctrl_vld_sel = 0;
        trig_offset = '0; din = '0; din_vld = 0; trig = 0;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst.we", bram_we, 0);
        chk("rst.addr", bram_addr, 0);
        chk("rst.din", bram_din, 0);
        chk("rst.busy", status_busy, 0);
        chk("rst.done", status_done, 0);
        chk("rst.count", status_count, 0);
        @(posedge user_clk); #1 user_rst = 1'b0;

        for (int sc = 0; sc < 7; sc++) begin
            gen(sc);
            model();
            run_and_check(sc);
        end

        // reset in the middle of a capture
        @(posedge user_clk); #1;
        ctrl_arm = 0; ctrl_trig_sel = 0; ctrl_vld_sel = 0; trig_offset = '0;
        @(posedge user_clk); #1 ctrl_arm = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge user_clk); #1 din = $urandom;
            @(negedge user_clk);
            if (status_count == 100) found = 1'b1;
        end
        chk("midrst.reach100", found, 1);
        chk("midrst.we_before", bram_we, 1);
        chk("midrst.busy_before", status_busy, 1);
        user_rst = 1'b1;
        ctrl_arm = 1'b0;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("midrst.we", bram_we, 0);
        chk("midrst.count", status_count, 0);
        chk("midrst.busy", status_busy, 0);
        chk("midrst.done", status_done, 0);
        chk("midrst.addr", bram_addr, 0);
        @(posedge user_clk); #1 user_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge user_clk);
            chk($sformatf("idle.busy%0d", i), status_busy, 0);
            chk($sformatf("idle.we%0d", i), bram_we, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
